// File: rtl/dual_port_ram_bist_pkg.sv
// Shared encodings for the March C- BIST controller: FSM states, R/W phase
// and the per-element direction / read-pattern / write-pattern table.
package dual_port_ram_bist_pkg;

    typedef enum logic [3:0] {
        IDLE,
        M0,
        M1,
        M2,
        M3,
        M4,
        M5,
        M5_LAST,
        DONE
    } state_t;

    typedef enum logic {
        PH_R,
        PH_W
    } phase_t;

    // Bit i of each mask describes March element Mi (M0..M5).
    localparam logic [5:0] ELEM_DOWN = 6'b011000;
    localparam logic [5:0] ELEM_RPAT = 6'b010100;
    localparam logic [5:0] ELEM_WPAT = 6'b001010;

    function automatic logic [2:0] elem_idx(input state_t s);
        case (s)
            M0:      return 3'd0;
            M1:      return 3'd1;
            M2:      return 3'd2;
            M3:      return 3'd3;
            M4:      return 3'd4;
            M5:      return 3'd5;
            M5_LAST: return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic state_t next_elem(input state_t s);
        case (s)
            M0:      return M1;
            M1:      return M2;
            M2:      return M3;
            M3:      return M4;
            M4:      return M5;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/dual_port_ram_bist_addr_gen.sv
// Up/down address counter for the BIST: loads the element start address and
// flags (registered) when the element-terminal address is reached.
module bist_addr_gen #(
    parameter int unsigned MEM_LENGTH = 64,
    parameter int unsigned AW         = $clog2(MEM_LENGTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic          dir,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [AW-1:0] TOP_ADDR = AW'(MEM_LENGTH - 1);

    logic [AW-1:0] addr_nxt;

    always_comb begin
        addr_nxt = dir ? (addr - AW'(1)) : (addr + AW'(1));
    end

    // With MEM_LENGTH >= 2 a freshly loaded start address is never terminal.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr <= '0;
            last <= 1'b0;
        end else if (load) begin
            addr <= dir ? TOP_ADDR : '0;
            last <= 1'b0;
        end else if (step) begin
            addr <= addr_nxt;
            last <= dir ? (addr_nxt == '0) : (addr_nxt == TOP_ADDR);
        end
    end

endmodule

// File: rtl/dual_port_ram_bist.sv
// March C- self-test initiator for Dual_port_ram: writes through port a,
// reads through port b, reports pass/fail, first failing word and error count.
module dual_port_ram_bist
    import dual_port_ram_bist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_LENGTH = 64,
    parameter int unsigned ERR_W      = 8,
    localparam int unsigned AW        = $clog2(MEM_LENGTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [AW-1:0]         fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [ERR_W-1:0]      err_count,
    output logic                  wen_a,
    output logic [AW-1:0]         write_address_a,
    output logic [DATA_WIDTH-1:0] data_in_a,
    output logic [AW-1:0]         read_address_b,
    input  logic [DATA_WIDTH-1:0] data_out_b
);

    state_t        state;
    phase_t        phase;
    logic [AW-1:0] addr;
    logic          addr_last;
    logic          cnt_load;
    logic          cnt_step;
    logic          cnt_dir;
    logic [AW-1:0] cmp_addr_q;
    logic          m5_pend;
    logic          cmp_en;
    logic          cmp_bit;
    logic [AW-1:0] cmp_addr;
    logic          miscompare;

    bist_addr_gen #(
        .MEM_LENGTH(MEM_LENGTH),
        .AW        (AW)
    ) u_addr_gen (
        .clk (clk),
        .rst (rst),
        .load(cnt_load),
        .step(cnt_step),
        .dir (cnt_dir),
        .addr(addr),
        .last(addr_last)
    );

    assign write_address_a = addr;
    assign read_address_b  = addr;

    always_comb begin
        cnt_load = 1'b0;
        cnt_step = 1'b0;
        cnt_dir  = ELEM_DOWN[elem_idx(state)];
        cmp_en   = 1'b0;
        cmp_bit  = ELEM_RPAT[elem_idx(state)];
        cmp_addr = addr;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    cnt_load = 1'b1;
                    cnt_dir  = ELEM_DOWN[0];
                end
            end
            M0: begin
                if (addr_last) begin
                    cnt_load = 1'b1;
                    cnt_dir  = ELEM_DOWN[elem_idx(next_elem(state))];
                end else begin
                    cnt_step = 1'b1;
                end
            end
            M1, M2, M3, M4: begin
                if (phase == PH_W) begin
                    cmp_en = 1'b1;
                    if (addr_last) begin
                        cnt_load = 1'b1;
                        cnt_dir  = ELEM_DOWN[elem_idx(next_elem(state))];
                    end else begin
                        cnt_step = 1'b1;
                    end
                end
            end
            // M5 is pipelined: this cycle checks the word issued one cycle earlier.
            M5: begin
                cmp_en   = m5_pend;
                cmp_addr = cmp_addr_q;
                cnt_step = !addr_last;
            end
            M5_LAST: begin
                cmp_en   = 1'b1;
                cmp_addr = cmp_addr_q;
            end
            default: ;
        endcase
        miscompare = cmp_en && (data_out_b != {DATA_WIDTH{cmp_bit}});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            phase      <= PH_R;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_data  <= '0;
            err_count  <= '0;
            wen_a      <= 1'b0;
            data_in_a  <= '0;
            cmp_addr_q <= '0;
            m5_pend    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= M0;
                        phase      <= PH_R;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        fail       <= 1'b0;
                        fail_addr  <= '0;
                        fail_data  <= '0;
                        err_count  <= '0;
                        wen_a      <= 1'b1;
                        data_in_a  <= '0;
                        cmp_addr_q <= '0;
                        m5_pend    <= 1'b0;
                    end
                end
                M0: begin
                    if (addr_last) begin
                        state <= M1;
                        phase <= PH_R;
                        wen_a <= 1'b0;
                    end
                end
                M1, M2, M3, M4: begin
                    if (phase == PH_R) begin
                        phase     <= PH_W;
                        wen_a     <= 1'b1;
                        data_in_a <= {DATA_WIDTH{ELEM_WPAT[elem_idx(state)]}};
                    end else begin
                        phase <= PH_R;
                        wen_a <= 1'b0;
                        if (addr_last) begin
                            state <= next_elem(state);
                        end
                    end
                end
                M5: begin
                    m5_pend    <= 1'b1;
                    cmp_addr_q <= addr;
                    if (addr_last) begin
                        state <= M5_LAST;
                    end
                end
                M5_LAST: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            if (miscompare) begin
                fail <= 1'b1;
                if (!fail) begin
                    fail_addr <= cmp_addr;
                    fail_data <= data_out_b;
                end
                if (err_count != '1) begin
                    err_count <= err_count + ERR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dual_port_ram_bist.sv
// Self-checking bench for dual_port_ram_bist: behavioural RAM with injectable
// stuck-at faults, write-sequence scoreboard and per-run result vectors.
module tb_dual_port_ram_bist;

    localparam int DW = 8;
    localparam int N  = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, fail, wen_a;
    logic [AW-1:0] fail_addr, write_address_a, read_address_b;
    logic [DW-1:0] fail_data, data_in_a;
    logic [DW-1:0] data_out_b = '0;
    logic [7:0]    err_count;

    logic          start2 = 1'b0;
    logic          busy2, done2, fail2, wen_a2;
    logic [AW-1:0] fail_addr2, write_address_a2, read_address_b2;
    logic [DW-1:0] fail_data2, data_in_a2;
    logic [DW-1:0] data_out_b2 = '0;
    logic [3:0]    err_count2;

    always #5 clk = ~clk;

    dual_port_ram_bist #(.DATA_WIDTH(DW), .MEM_LENGTH(N), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .fail(fail), .fail_addr(fail_addr), .fail_data(fail_data),
        .err_count(err_count), .wen_a(wen_a), .write_address_a(write_address_a),
        .data_in_a(data_in_a), .read_address_b(read_address_b), .data_out_b(data_out_b)
    );

    dual_port_ram_bist #(.DATA_WIDTH(DW), .MEM_LENGTH(N), .ERR_W(4)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .fail(fail2), .fail_addr(fail_addr2), .fail_data(fail_data2),
        .err_count(err_count2), .wen_a(wen_a2), .write_address_a(write_address_a2),
        .data_in_a(data_in_a2), .read_address_b(read_address_b2), .data_out_b(data_out_b2)
    );

    // Behavioural RAM; faults are applied on the read path.
    logic [DW-1:0] mem [N];
    logic [DW-1:0] flt_and = '1;
    logic [DW-1:0] flt_or  = '0;
    int            flt_addr = -1;

    function automatic logic [DW-1:0] read_fault(input logic [DW-1:0] d, input logic [AW-1:0] a);
        if (flt_addr < 0 || int'(a) == flt_addr) return (d & flt_and) | flt_or;
        return d;
    endfunction

    always @(posedge clk) begin
        if (wen_a) mem[write_address_a] <= data_in_a;
        data_out_b  <= read_fault(mem[read_address_b], read_address_b);
        data_out_b2 <= 8'hA5;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_wr[$];

    // Every RAM write must match the next expected March C- write.
    always @(negedge clk) begin
        if (wen_a) begin
            check("write_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
                check("wr_addr", 32'(write_address_a), 32'(exp_wr[0].a));
                check("wr_data", 32'(data_in_a), 32'(exp_wr[0].d));
                void'(exp_wr.pop_front());
            end
        end
    end

    task automatic push_writes();
        for (int e = 0; e < 5; e++) begin
            for (int j = 0; j < N; j++) begin
                wr_t w;
                w.a = (e >= 3) ? AW'(N - 1 - j) : AW'(j);
                w.d = (e == 1 || e == 3) ? 8'hFF : 8'h00;
                exp_wr.push_back(w);
            end
        end
    endtask

    typedef struct {
        logic [DW-1:0] f_and;
        logic [DW-1:0] f_or;
        int            f_addr;
        bit            repulse;
        bit            e_fail;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        int            e_err;
    } vec_t;

    vec_t exp_res[$];

    task automatic run_vec(input vec_t v, input string tag);
        vec_t e;
        int   bc;
        int   wc;
        flt_and  = v.f_and;
        flt_or   = v.f_or;
        flt_addr = v.f_addr;
        push_writes();
        exp_res.push_back(v);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy_after_start"}, 32'(busy), 32'd1);
        check({tag, " done_cleared"}, 32'(done), 32'd0);
        check({tag, " fail_cleared"}, 32'(fail), 32'd0);
        check({tag, " err_cleared"}, 32'(err_count), 32'd0);
        check({tag, " fail_addr_cleared"}, 32'(fail_addr), 32'd0);
        bc = 0;
        wc = 0;
        while (busy && bc < 2000) begin
            bc++;
            if (wen_a) wc++;
            start = v.repulse && (bc == 100);
            @(negedge clk);
        end
        start = 1'b0;
        e = exp_res.pop_front();
        check({tag, " busy_cycles"}, 32'(bc), 32'd641);
        check({tag, " wen_cycles"}, 32'(wc), 32'd320);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " wen_idle"}, 32'(wen_a), 32'd0);
        check({tag, " fail"}, 32'(fail), 32'(e.e_fail));
        check({tag, " fail_addr"}, 32'(fail_addr), 32'(e.e_addr));
        check({tag, " fail_data"}, 32'(fail_data), 32'(e.e_data));
        check({tag, " err_count"}, 32'(err_count), 32'(e.e_err));
        check({tag, " writes_left"}, 32'(exp_wr.size()), 32'd0);
        repeat (3) @(negedge clk);
        check({tag, " done_held"}, 32'(done), 32'd1);
        check({tag, " err_held"}, 32'(err_count), 32'(e.e_err));
    endtask

    vec_t vecs[4];
    vec_t clean;

    initial begin
        int bc;
        clean   = '{8'hFF, 8'h00, -1, 1'b0, 1'b0, 6'd0, 8'h00, 0};
        vecs[0] = clean;
        vecs[1] = '{8'hF7, 8'h00, 5, 1'b0, 1'b1, 6'd5, 8'hF7, 2};
        vecs[2] = '{8'hFF, 8'h01, -1, 1'b0, 1'b1, 6'd0, 8'h01, 192};
        vecs[3] = '{8'hFF, 8'h00, -1, 1'b1, 1'b0, 6'd0, 8'h00, 0};
        for (int i = 0; i < N; i++) mem[i] = '0;

        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_wen", 32'(wen_a), 32'd0);
        check("rst_waddr", 32'(write_address_a), 32'd0);
        check("rst_raddr", 32'(read_address_b), 32'd0);
        check("rst_din", 32'(data_in_a), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of M3, then a fresh full pass.
        flt_and  = '1;
        flt_or   = '0;
        flt_addr = -1;
        push_writes();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bc = 1;
        while (bc < 330 && busy) begin
            @(negedge clk);
            bc++;
        end
        check("mid_run_busy_before_rst", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_wen", 32'(wen_a), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_waddr", 32'(write_address_a), 32'd0);
        exp_wr.delete();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_idle_busy", 32'(busy), 32'd0);
        check("post_rst_idle_wen", 32'(wen_a), 32'd0);
        run_vec(clean, "post_rst");

        // Narrow saturating counter with every word reading 0xA5.
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        bc = 0;
        while (busy2 && bc < 2000) begin
            bc++;
            @(negedge clk);
        end
        check("sat_busy_cycles", 32'(bc), 32'd641);
        check("sat_done", 32'(done2), 32'd1);
        check("sat_fail", 32'(fail2), 32'd1);
        check("sat_err_count", 32'(err_count2), 32'd15);
        check("sat_fail_addr", 32'(fail_addr2), 32'd0);
        check("sat_fail_data", 32'(fail_data2), 32'hA5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
